// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The MEM_* codes match the control unit's Mem_Write_Read encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyD,
    StResp
  } arb_state_e;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WR   = 2'b01;
  localparam logic [1:0] MEM_RD   = 2'b10;

  // Little-endian byte enables: one lane for byte ops, all lanes for words.
  function automatic logic [3:0] byte_en(input logic byte_op, input logic [1:0] lane);
    byte_en = byte_op ? (4'b0001 << lane) : 4'hF;
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: store replication / byte enables and load lane extract with zero-extension.
module mem_byte_lane
  import mem_arb_pkg::*;
(
  input  logic        byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Steer store data onto all lanes and pick the addressed load byte.
  always_comb begin
    be_o    = byte_en(byte_i, lane_i);
    wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
    rdata_o = byte_i ? {24'b0, rdata_i[8*lane_i +: 8]} : rdata_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_MAX times in a row.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned word accesses instead of issuing them).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_rw,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              misalign
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic              misalign_q, misalign_d;
  logic [1:0]        lane_q, lane_d;
  logic              byte_q, byte_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic        d_pend, grant_d, grant_if, trap_d, trap_if;
  logic [1:0]  lane_sel;
  logic        byte_sel;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // Requests with d_rw of 00/11 are not real accesses.
  assign d_pend   = d_req & ((d_rw == MEM_WR) | (d_rw == MEM_RD));
  assign grant_d  = d_pend & ~(if_req & (starve_q == StarveMax));
  assign grant_if = if_req & ~grant_d;

`ifdef MISALIGN_TRAP_EN
  assign trap_d  = ~d_byte & (d_addr[1:0] != 2'b00);
  assign trap_if = (if_addr[1:0] != 2'b00);
`else
  logic unused_if_lo;
  assign trap_d       = 1'b0;
  assign trap_if      = 1'b0;
  assign unused_if_lo = ^if_addr[1:0];
`endif

  // Store path uses live request fields at grant; load path uses the lane latched at grant.
  assign lane_sel = (state_q == StIdle) ? d_addr[1:0] : lane_q;
  assign byte_sel = (state_q == StIdle) ? d_byte : byte_q;

  mem_byte_lane u_lane (
    .byte_i  (byte_sel),
    .lane_i  (lane_sel),
    .wdata_i (d_wdata),
    .rdata_i (mem_rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  // Next-state: arbitration in idle, completion capture in busy, one-cycle response pulse.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lane_d      = lane_q;
    byte_d      = byte_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    misalign_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          if (if_req && (starve_q != StarveMax)) starve_d = starve_q + 4'd1;
          if (trap_d) begin
            state_d    = StResp;
            d_valid_d  = 1'b1;
            misalign_d = 1'b1;
            d_rdata_d  = '0;
          end else begin
            state_d     = StBusyD;
            mem_en_d    = 1'b1;
            mem_we_d    = (d_rw == MEM_WR);
            mem_be_d    = lane_be;
            mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = (d_rw == MEM_WR) ? lane_wdata : '0;
            lane_d      = d_addr[1:0];
            byte_d      = d_byte;
          end
        end else if (grant_if) begin
          starve_d = '0;
          if (trap_if) begin
            state_d    = StResp;
            if_valid_d = 1'b1;
            misalign_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            state_d     = StBusyIf;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = '0;
          end
        end
      end
      StBusyIf: begin
        if (mem_ready) begin
          state_d    = StResp;
          mem_en_d   = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
        end
      end
      StBusyD: begin
        if (mem_ready) begin
          state_d   = StResp;
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          d_rdata_d = mem_we_q ? '0 : lane_rdata;
          d_valid_d = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lane_q      <= lane_d;
      byte_q      <= byte_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign misalign  = misalign_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_pend & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus randomized traffic against a byte-array model.
// Honours MISALIGN_TRAP_EN when defined for the build.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_valid, d_req, d_byte, d_valid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0]  d_rw;
  logic        mem_en, mem_we, mem_ready, stall_if, stall_mem, misalign;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit auto_mem = 1'b0;

  logic [31:0] mem_w   [0:127];
  logic [7:0]  ref_mem [0:511];

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_byte    (d_byte),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w;
    w = int'(a & 32'h1FC);
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  // Memory slave with random latency (0..3 extra cycles), active only in auto mode.
  initial begin : responder
    int dly;
    bit busy;
    dly  = 0;
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (rst || !mem_en) begin
          mem_ready = 1'b0;
          busy      = 1'b0;
        end else begin
          if (!busy) begin
            busy = 1'b1;
            dly  = int'($urandom_range(0, 3));
          end
          if (dly == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem_w[mem_addr[8:2]];
            if (mem_we)
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_w[mem_addr[8:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            busy = 1'b0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            dly--;
          end
        end
      end
    end
  end

  // One request (fetch, data or both) to completion, checked against the byte-array model.
  task automatic txn(input string tag, input bit use_if, input logic [31:0] ia, input bit use_d,
                     input logic [1:0] rw, input bit bt, input logic [31:0] da,
                     input logic [31:0] wd);
    logic [31:0] exp_i, exp_d, got_i, got_d;
    bit seen_i, seen_d;
    int n;
    exp_i = ref_word(ia);
    if (rw == MEM_RD) exp_d = bt ? {24'b0, ref_mem[da[8:0]]} : ref_word(da);
    else exp_d = 32'h0;
    if (use_d && rw == MEM_WR) begin
      if (bt) ref_mem[da[8:0]] = wd[7:0];
      else for (int b = 0; b < 4; b++) ref_mem[int'(da & 32'h1FC) + b] = wd[8*b +: 8];
    end
    got_i = 'x;
    got_d = 'x;
    if_req  = use_if;
    if_addr = ia;
    d_req   = use_d;
    d_rw    = rw;
    d_byte  = bt;
    d_addr  = da;
    d_wdata = wd;
    seen_i  = !use_if;
    seen_d  = !use_d;
    n = 0;
    while (!(seen_i && seen_d) && n < 100) begin
      tick();
      n++;
      if (if_valid) begin got_i = if_rdata; seen_i = 1'b1; if_req = 1'b0; end
      if (d_valid) begin got_d = d_rdata; seen_d = 1'b1; d_req = 1'b0; end
    end
    chk({tag, "_done"}, {30'b0, seen_i, seen_d}, 32'h3);
    if (use_if) chk({tag, "_if_rdata"}, got_i, exp_i);
    if (use_d) chk({tag, "_d_rdata"}, got_d, exp_d);
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, n;
    bit exp_if;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = MEM_NONE; d_byte = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      mem_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem_w[i][8*b +: 8];
    end
    #2;
    chk("rst_ctrl", {27'b0, if_valid, d_valid, mem_en, mem_we, misalign}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Lone lw at 0x10, memory answers one cycle after mem_en.
    d_req = 1'b1; d_rw = MEM_RD; d_byte = 1'b0; d_addr = 32'h10;
    tick();
    chk("lw_en", mem_en, 1);
    chk("lw_we", mem_we, 0);
    chk("lw_be", mem_be, 4'hF);
    chk("lw_addr", mem_addr, 32'h10);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    chk("lw_valid_c3", d_valid, 0);
    tick();
    chk("lw_valid_c4", d_valid, 1);
    chk("lw_rdata", d_rdata, 32'hDEADBEEF);
    chk("lw_en_resp", mem_en, 0);
    chk("lw_stall_resp", stall_mem, 0);
    mem_ready = 1'b0; mem_rdata = '0; d_req = 1'b0;
    tick();
    chk("lw_valid_after", d_valid, 0);

    // Reset in the middle of a data access.
    d_req = 1'b1; d_rw = MEM_RD; d_addr = 32'h30;
    tick();
    chk("rstmid_busy_en", mem_en, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ctrl", {27'b0, if_valid, d_valid, mem_en, mem_we, misalign}, 32'h0);
    chk("rstmid_addr", mem_addr, 32'h0);
    chk("rstmid_be", {28'b0, mem_be}, 32'h0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ready = 1'b0;
    chk("rstmid_no_valid", d_valid, 0);
    chk("rstmid_no_en", mem_en, 0);
    tick();
    chk("rstmid_no_valid2", d_valid, 0);

    // lbu at 0x13 completing on the first mem_en cycle.
    d_req = 1'b1; d_rw = MEM_RD; d_byte = 1'b1; d_addr = 32'h13;
    tick();
    chk("lbu_en", mem_en, 1);
    mem_ready = 1'b1; mem_rdata = 32'hA1B2C3D4;
    tick();
    chk("lbu_valid", d_valid, 1);
    chk("lbu_rdata", d_rdata, 32'h000000A1);
    mem_ready = 1'b0; d_req = 1'b0;
    tick();

    // sb at 0x11: only the low byte of d_wdata is stored, on lane 1.
    d_req = 1'b1; d_rw = MEM_WR; d_byte = 1'b1; d_addr = 32'h11; d_wdata = 32'hCCCCCC5A;
    tick();
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h10);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("sb_valid", d_valid, 1);
    chk("sb_rdata", d_rdata, 32'h0);
    mem_ready = 1'b0; d_req = 1'b0;
    tick();

    // Slow memory: ten wait cycles with everything held.
    d_req = 1'b1; d_rw = MEM_RD; d_byte = 1'b0; d_addr = 32'h40;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("slow_en%0d", i), mem_en, 1);
      chk($sformatf("slow_addr%0d", i), mem_addr, 32'h40);
      chk($sformatf("slow_stall%0d", i), stall_mem, 1);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'h13572468;
    chk("slow_stall_last", stall_mem, 1);
    tick();
    chk("slow_valid", d_valid, 1);
    chk("slow_rdata", d_rdata, 32'h13572468);
    chk("slow_stall_done", stall_mem, 0);
    mem_ready = 1'b0; d_req = 1'b0;
    tick();

    // Misaligned word load at 0x22.
    d_req = 1'b1; d_rw = MEM_RD; d_byte = 1'b0; d_addr = 32'h22;
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_en", mem_en, 0);
    chk("mis_valid", d_valid, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    chk("mis_valid_off", d_valid, 0);
    chk("mis_flag_off", misalign, 0);
`else
    chk("mis_addr", mem_addr, 32'h20);
    chk("mis_en", mem_en, 1);
    chk("mis_flag", misalign, 0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("mis_valid", d_valid, 1);
    chk("mis_rdata", d_rdata, 32'hCAFEF00D);
    mem_ready = 1'b0; d_req = 1'b0;
    tick();
`endif

    // Both requesters held: every fifth grant goes to fetch.
    auto_mem = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_rw = MEM_RD; d_byte = 1'b0; d_addr = 32'h0;
    k = 0;
    n = 0;
    while (k < 10 && n < 300) begin
      tick();
      n++;
      if (if_valid || d_valid) begin
        exp_if = (k % 5 == 4);
        chk($sformatf("starve_grant%0d", k), {31'b0, if_valid}, {31'b0, exp_if});
        chk($sformatf("starve_stall_if%0d", k), {31'b0, stall_if}, {31'b0, !exp_if});
        if (exp_if) chk($sformatf("starve_if_rdata%0d", k), if_rdata, ref_word(32'h100));
        else chk($sformatf("starve_d_rdata%0d", k), d_rdata, ref_word(32'h0));
        k++;
      end
    end
    chk("starve_count", k, 10);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Random traffic: fetch from 0x100..0x1FC, data in 0x000..0x0FF.
    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [31:0] ia, da, wd;
      logic [1:0] rw;
      bit bt;
      kind = int'($urandom_range(0, 2));
      ia   = 32'h100 + 32'($urandom_range(0, 63)) * 4;
      rw   = ($urandom_range(0, 1) == 1) ? MEM_WR : MEM_RD;
      bt   = 1'($urandom_range(0, 1));
      da   = 32'($urandom_range(0, 255));
`ifdef MISALIGN_TRAP_EN
      if (!bt) da[1:0] = 2'b00;
`endif
      wd = $urandom;
      txn($sformatf("rnd%0d", it), kind != 1, ia, kind != 0, rw, bt, da, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
